// File: rtl/axi4_lite_write_slave_endpoint_pkg.sv
// Shared types and defaults for the AXI4-Lite write-slave endpoint.
// Optional ready-delay feature is selected by AXI4LITE_WRITE_SLAVE_READY_DELAY_EN.
package Axi4LiteWriteSlaveGlobalPkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_DELAY_WIDTH   = 5;

    localparam logic [31:0] DEFAULT_MIN_ADDRESS = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_MAX_ADDRESS = 32'h0000_0FFF;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } brespEnum;

    function automatic int strbWidth(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/axi4_lite_write_slave_endpoint_chan_buf.sv
// One-entry holding buffer with registered ready for a single AXI4-Lite channel.
// With AXI4LITE_WRITE_SLAVE_READY_DELAY_EN, ready is held off by a loadable delay counter.
module axi4_lite_write_chan_buf
    import Axi4LiteWriteSlaveGlobalPkg::*;
#(
    parameter int WIDTH         = 8,
    parameter bit DEFAULT_READY = 1'b0
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
    ,
    parameter int DELAY_WIDTH   = DEFAULT_DELAY_WIDTH
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
    input  logic [DELAY_WIDTH-1:0] delay_i,
`endif
    output logic             ready_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             handshake;
    logic             rise;
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic                   cntActive_q, cntActive_d;
`endif

    assign handshake = valid_i & ready_q;

    // A handshake can never coincide with a clear: ready is low whenever the buffer is full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (handshake) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (clear_i) begin
            full_d = 1'b0;
        end
    end

    assign rise = DEFAULT_READY ? (!full_d && !ready_q)
                                : (!full_q && valid_i && !ready_q);

    always_comb begin
        ready_d = ready_q;
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
        cnt_d       = cnt_q;
        cntActive_d = cntActive_q;
`endif
        if (handshake) begin
            ready_d = 1'b0;
        end else if (rise) begin
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
            if (cntActive_q) begin
                if (cnt_q <= DELAY_WIDTH'(1)) begin
                    ready_d     = 1'b1;
                    cntActive_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else if (delay_i == '0) begin
                ready_d = 1'b1;
            end else begin
                cnt_d       = delay_i;
                cntActive_d = 1'b1;
            end
`else
            ready_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            ready_q <= DEFAULT_READY;
            data_q  <= '0;
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
            cnt_q       <= '0;
            cntActive_q <= 1'b0;
`endif
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
            cnt_q       <= cnt_d;
            cntActive_q <= cntActive_d;
`endif
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axi4_lite_write_slave_endpoint.sv
// AXI4-Lite write slave: pairs AW/W, decodes the address and drives a one-cycle register write strobe.
// Optional ready-delay inputs are enabled by AXI4LITE_WRITE_SLAVE_READY_DELAY_EN.
module axi4_lite_write_slave_endpoint
    import Axi4LiteWriteSlaveGlobalPkg::*;
#(
    parameter int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter bit DEFAULT_AWREADY = 1'b0,
    parameter bit DEFAULT_WREADY  = 1'b0,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = ADDRESS_WIDTH'(DEFAULT_MIN_ADDRESS),
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = ADDRESS_WIDTH'(DEFAULT_MAX_ADDRESS)
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
    ,
    parameter int DELAY_WIDTH     = DEFAULT_DELAY_WIDTH
`endif
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDRESS_WIDTH-1:0]   awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    output logic                       wr_en,
    output logic [ADDRESS_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]      wr_data,
    output logic [DATA_WIDTH/8-1:0]    wr_strb,
    output logic [2:0]                 wr_prot
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
    ,
    input  logic [DELAY_WIDTH-1:0]     delay_awready,
    input  logic [DELAY_WIDTH-1:0]     delay_wready
`endif
);

    localparam int STRB_WIDTH = strbWidth(DATA_WIDTH);
    localparam int ALIGN_BITS = $clog2(STRB_WIDTH);
    localparam int AW_WIDTH   = ADDRESS_WIDTH + 3;
    localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;

    logic                     awFull, wFull;
    logic [AW_WIDTH-1:0]      awHeld;
    logic [W_WIDTH-1:0]       wHeld;
    logic [ADDRESS_WIDTH-1:0] awAddrHeld;
    logic [2:0]               awProtHeld;
    logic [DATA_WIDTH-1:0]    wDataHeld;
    logic [STRB_WIDTH-1:0]    wStrbHeld;

    logic                     belowMin, aboveMax, misaligned;
    brespEnum                 resp;
    logic                     writeOk;
    logic                     fire;

    logic                     wrEn_q, wrEn_d;
    logic [ADDRESS_WIDTH-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_WIDTH-1:0]    wrData_q, wrData_d;
    logic [STRB_WIDTH-1:0]    wrStrb_q, wrStrb_d;
    logic [2:0]               wrProt_q, wrProt_d;
    logic                     pending_q, pending_d;
    brespEnum                 pendResp_q, pendResp_d;
    logic                     bvalid_q, bvalid_d;
    brespEnum                 bresp_q, bresp_d;

    axi4_lite_write_chan_buf #(
        .WIDTH         (AW_WIDTH),
        .DEFAULT_READY (DEFAULT_AWREADY)
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
        ,
        .DELAY_WIDTH   (DELAY_WIDTH)
`endif
    ) awBuf (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (awvalid),
        .data_i  ({awprot, awaddr}),
        .clear_i (pending_q),
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
        .delay_i (delay_awready),
`endif
        .ready_o (awready),
        .full_o  (awFull),
        .data_o  (awHeld)
    );

    axi4_lite_write_chan_buf #(
        .WIDTH         (W_WIDTH),
        .DEFAULT_READY (DEFAULT_WREADY)
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
        ,
        .DELAY_WIDTH   (DELAY_WIDTH)
`endif
    ) wBuf (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (wvalid),
        .data_i  ({wstrb, wdata}),
        .clear_i (pending_q),
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
        .delay_i (delay_wready),
`endif
        .ready_o (wready),
        .full_o  (wFull),
        .data_o  (wHeld)
    );

    assign awAddrHeld = awHeld[ADDRESS_WIDTH-1:0];
    assign awProtHeld = awHeld[AW_WIDTH-1 -: 3];
    assign wDataHeld  = wHeld[DATA_WIDTH-1:0];
    assign wStrbHeld  = wHeld[W_WIDTH-1 -: STRB_WIDTH];

    // Range bounds at the ends of the address space can never be violated, so skip the compare.
    generate
        if (MIN_ADDRESS == '0) begin : gNoMin
            assign belowMin = 1'b0;
        end else begin : gMin
            assign belowMin = awAddrHeld < MIN_ADDRESS;
        end
        if (MAX_ADDRESS == '1) begin : gNoMax
            assign aboveMax = 1'b0;
        end else begin : gMax
            assign aboveMax = awAddrHeld > MAX_ADDRESS;
        end
    endgenerate

    assign misaligned = |awAddrHeld[ALIGN_BITS-1:0];

    always_comb begin
        resp    = BRESP_OKAY;
        writeOk = 1'b0;
        if (belowMin || aboveMax) begin
            resp = BRESP_DECERR;
        end else if (misaligned) begin
            resp = BRESP_SLVERR;
        end else if (wStrbHeld != '0) begin
            writeOk = 1'b1;
        end
    end

    // pending_q marks the cycle between the write strobe and bvalid, when both buffers are still full.
    assign fire = awFull & wFull & !bvalid_q & !pending_q;

    always_comb begin
        wrEn_d     = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        wrStrb_d   = wrStrb_q;
        wrProt_d   = wrProt_q;
        pending_d  = 1'b0;
        pendResp_d = pendResp_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        if (fire) begin
            wrEn_d     = writeOk;
            wrAddr_d   = awAddrHeld;
            wrData_d   = wDataHeld;
            wrStrb_d   = wStrbHeld;
            wrProt_d   = awProtHeld;
            pending_d  = 1'b1;
            pendResp_d = resp;
        end
        if (pending_q) begin
            bvalid_d = 1'b1;
            bresp_d  = pendResp_q;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            wrStrb_q   <= '0;
            wrProt_q   <= '0;
            pending_q  <= 1'b0;
            pendResp_q <= BRESP_OKAY;
            bvalid_q   <= 1'b0;
            bresp_q    <= BRESP_OKAY;
        end else begin
            wrEn_q     <= wrEn_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            wrStrb_q   <= wrStrb_d;
            wrProt_q   <= wrProt_d;
            pending_q  <= pending_d;
            pendResp_q <= pendResp_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    assign wr_en   = wrEn_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;
    assign wr_strb = wrStrb_q;
    assign wr_prot = wrProt_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi4_lite_write_slave_endpoint.sv
// Directed bench for axi4_lite_write_slave_endpoint with default parameters.
module tb_axi4_lite_write_slave_endpoint;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [1:0]  bresp;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [2:0]  wr_prot;

    int passCount = 0;
    int checkCount = 0;
    int failCount = 0;

    axi4_lite_write_slave_endpoint dut (
        .aclk    (aclk),
        .areset  (areset),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .wr_prot (wr_prot)
`ifdef AXI4LITE_WRITE_SLAVE_READY_DELAY_EN
        ,
        .delay_awready (5'd0),
        .delay_wready  (5'd0)
`endif
    );

    always #5 aclk = ~aclk;

    // Watchdog so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic awv, input logic [31:0] addr,
                                 input logic wv, input logic [31:0] data, input logic [3:0] strb);
        awvalid = awv;
        awaddr  = addr;
        wvalid  = wv;
        wdata   = data;
        wstrb   = strb;
    endtask

    // AW and W presented together with bready high; checks strobe and response timing.
    task automatic runPair(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic expWrEn, input logic [1:0] expResp);
        applyStimulus(1'b1, addr, 1'b1, data, strb);
        @(negedge aclk);
        checkOutput({tag, " awready up"}, 64'(awready), 64'd1);
        checkOutput({tag, " wready up"}, 64'(wready), 64'd1);
        @(negedge aclk);
        applyStimulus(1'b0, addr, 1'b0, data, strb);
        checkOutput({tag, " awready down"}, 64'(awready), 64'd0);
        @(negedge aclk);
        checkOutput({tag, " wr_en"}, 64'(wr_en), 64'(expWrEn));
        checkOutput({tag, " bvalid early"}, 64'(bvalid), 64'd0);
        if (expWrEn) begin
            checkOutput({tag, " wr_addr"}, 64'(wr_addr), 64'(addr));
            checkOutput({tag, " wr_data"}, 64'(wr_data), 64'(data));
            checkOutput({tag, " wr_strb"}, 64'(wr_strb), 64'(strb));
        end
        @(negedge aclk);
        checkOutput({tag, " bvalid"}, 64'(bvalid), 64'd1);
        checkOutput({tag, " bresp"}, 64'(bresp), 64'(expResp));
        checkOutput({tag, " wr_en single"}, 64'(wr_en), 64'd0);
        @(negedge aclk);
        checkOutput({tag, " bvalid cleared"}, 64'(bvalid), 64'd0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge aclk);
        checkOutput("reset awready", 64'(awready), 64'd0);
        checkOutput("reset wready", 64'(wready), 64'd0);
        checkOutput("reset bvalid", 64'(bvalid), 64'd0);
        checkOutput("reset bresp", 64'(bresp), 64'd0);
        checkOutput("reset wr_en", 64'(wr_en), 64'd0);
        checkOutput("reset wr_addr", 64'(wr_addr), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("idle awready", 64'(awready), 64'd0);

        // Same-cycle AW/W with a protection value that must follow the address.
        awprot = 3'b010;
        runPair("same-cycle", 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 2'b00);
        checkOutput("same-cycle wr_prot", 64'(wr_prot), 64'd2);
        awprot = 3'b000;

        // W arrives well before AW and must be held.
        applyStimulus(1'b0, 32'h20, 1'b1, 32'h1234, 4'h3);
        @(negedge aclk);
        checkOutput("wfirst wready up", 64'(wready), 64'd1);
        checkOutput("wfirst awready idle", 64'(awready), 64'd0);
        @(negedge aclk);
        applyStimulus(1'b0, 32'h20, 1'b0, 32'h1234, 4'h3);
        checkOutput("wfirst wready down", 64'(wready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checkOutput("wfirst wready held", 64'(wready), 64'd0);
            checkOutput("wfirst no wr_en", 64'(wr_en), 64'd0);
        end
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h1234, 4'h3);
        @(negedge aclk);
        checkOutput("wfirst awready up", 64'(awready), 64'd1);
        @(negedge aclk);
        applyStimulus(1'b0, 32'h20, 1'b0, 32'h1234, 4'h3);
        checkOutput("wfirst wready still low", 64'(wready), 64'd0);
        @(negedge aclk);
        checkOutput("wfirst wr_en", 64'(wr_en), 64'd1);
        checkOutput("wfirst wr_strb", 64'(wr_strb), 64'h3);
        checkOutput("wfirst wr_addr", 64'(wr_addr), 64'h20);
        checkOutput("wfirst wr_data", 64'(wr_data), 64'h1234);
        @(negedge aclk);
        checkOutput("wfirst bvalid", 64'(bvalid), 64'd1);
        checkOutput("wfirst bresp", 64'(bresp), 64'd0);
        checkOutput("wfirst wr_en single", 64'(wr_en), 64'd0);
        @(negedge aclk);
        checkOutput("wfirst bvalid cleared", 64'(bvalid), 64'd0);

        // Response decode corners.
        runPair("decerr", 32'h2000, 32'h0, 4'hF, 1'b0, 2'b11);
        runPair("slverr", 32'h06, 32'h0, 4'hF, 1'b0, 2'b10);
        runPair("nostrb", 32'h30, 32'h77, 4'h0, 1'b0, 2'b00);
        runPair("maxaddr", 32'hFFC, 32'hCAFE_F00D, 4'h9, 1'b1, 2'b00);
        runPair("past-max", 32'h1000, 32'h0, 4'hF, 1'b0, 2'b11);

        // bready stall with a second pair buffered behind the pending response.
        bready = 1'b0;
        applyStimulus(1'b1, 32'h2000, 1'b1, 32'h1111_1111, 4'hF);
        @(negedge aclk);
        @(negedge aclk);
        applyStimulus(1'b0, 32'h2000, 1'b0, 32'h1111_1111, 4'hF);
        @(negedge aclk);
        checkOutput("stall first wr_en", 64'(wr_en), 64'd0);
        @(negedge aclk);
        checkOutput("stall bvalid", 64'(bvalid), 64'd1);
        applyStimulus(1'b1, 32'h44, 1'b1, 32'h5A5A_5A5A, 4'hF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge aclk);
            if (i == 2) applyStimulus(1'b0, 32'h44, 1'b0, 32'h5A5A_5A5A, 4'hF);
            checkOutput("stall bvalid held", 64'(bvalid), 64'd1);
            checkOutput("stall bresp held", 64'(bresp), 64'd3);
            checkOutput("stall no wr_en", 64'(wr_en), 64'd0);
        end
        checkOutput("stall awready full", 64'(awready), 64'd0);
        bready = 1'b1;
        @(negedge aclk);
        checkOutput("stall bvalid released", 64'(bvalid), 64'd0);
        checkOutput("stall wr_en not yet", 64'(wr_en), 64'd0);
        @(negedge aclk);
        checkOutput("stall second wr_en", 64'(wr_en), 64'd1);
        checkOutput("stall second wr_addr", 64'(wr_addr), 64'h44);
        checkOutput("stall second wr_data", 64'(wr_data), 64'h5A5A_5A5A);
        @(negedge aclk);
        checkOutput("stall second bvalid", 64'(bvalid), 64'd1);
        checkOutput("stall second bresp", 64'(bresp), 64'd0);
        @(negedge aclk);
        checkOutput("stall second bvalid cleared", 64'(bvalid), 64'd0);

        // Reset while AW is buffered and W has not arrived.
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 4'h0);
        @(negedge aclk);
        checkOutput("rst awready up", 64'(awready), 64'd1);
        @(negedge aclk);
        applyStimulus(1'b0, 32'h80, 1'b0, 32'h0, 4'h0);
        checkOutput("rst awready down", 64'(awready), 64'd0);
        @(negedge aclk);
        areset = 1'b1;
        #1;
        checkOutput("rst mid awready", 64'(awready), 64'd0);
        checkOutput("rst mid wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("rst mid wr_data", 64'(wr_data), 64'd0);
        checkOutput("rst mid bvalid", 64'(bvalid), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hCAFE, 4'hF);
        @(negedge aclk);
        checkOutput("rst w wready up", 64'(wready), 64'd1);
        @(negedge aclk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'hCAFE, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checkOutput("rst w alone no wr_en", 64'(wr_en), 64'd0);
            checkOutput("rst w alone no bvalid", 64'(bvalid), 64'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
